// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control: states, opcodes, ALUOp
// codes, datapath mux selects and the one-hot instruction class bits.
package mc_pkg;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_UPPER, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_ITYPE = 3'd3;
  localparam logic [2:0] ALU_PCADD = 3'd4;

  localparam logic [1:0] SA_PC    = 2'd0;
  localparam logic [1:0] SA_OLDPC = 2'd1;
  localparam logic [1:0] SA_REGA  = 2'd2;
  localparam logic [1:0] SA_ZERO  = 2'd3;

  localparam logic [1:0] SB_REGB = 2'd0;
  localparam logic [1:0] SB_IMM  = 2'd1;
  localparam logic [1:0] SB_FOUR = 2'd2;

  localparam logic [1:0] RS_ALUOUT = 2'd0;
  localparam logic [1:0] RS_DATA   = 2'd1;
  localparam logic [1:0] RS_ALURES = 2'd2;

  localparam int CL_MEM   = 0;
  localparam int CL_R     = 1;
  localparam int CL_I     = 2;
  localparam int CL_BR    = 3;
  localparam int CL_JAL   = 4;
  localparam int CL_JALR  = 5;
  localparam int CL_UPPER = 6;
  localparam int CL_ILL   = 7;
  localparam int CL_W     = 8;

  typedef logic [CL_W-1:0] iclass_t;

endpackage

// File: rtl/mc_main_control_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control out.
interface mc_main_control_if;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;
  logic [2:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  Opcode, Funct3, Zero, MemReady,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, MemRead, MemWrite,
           IRWrite, PCWrite, RegWrite, InstrDone, Illegal
  );

  modport slave (
    output Opcode, Funct3, Zero, MemReady,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, MemRead, MemWrite,
           IRWrite, PCWrite, RegWrite, InstrDone, Illegal
  );
endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational Opcode/Funct3 classifier; exactly one class bit is set.
module mc_opcode_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output iclass_t    cls
);
  always_comb begin
    cls = '0;
    case (opcode)
      OP_LOAD, OP_STORE: cls[CL_MEM]   = 1'b1;
      OP_R:              cls[CL_R]     = 1'b1;
      OP_I:              cls[CL_I]     = 1'b1;
      OP_JAL:            cls[CL_JAL]   = 1'b1;
      OP_JALR:           cls[CL_JALR]  = 1'b1;
      OP_LUI, OP_AUIPC:  cls[CL_UPPER] = 1'b1;
      // only beq/bne are supported
      OP_BRANCH: begin
        if (funct3[2:1] == 2'b00) cls[CL_BR]  = 1'b1;
        else                      cls[CL_ILL] = 1'b1;
      end
      default:           cls[CL_ILL]   = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_main_control.sv
// Multicycle main-control FSM: state register plus Moore output decode, with
// IRWrite/PCWrite/InstrDone qualified by MemReady or Zero where noted.
module mc_main_control
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mc_main_control_if.master  bus
);
  state_t  state;
  iclass_t cls;

  mc_opcode_decode u_dec (
    .opcode (bus.Opcode),
    .funct3 (bus.Funct3),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      case (state)
        S_BOOT:   state <= S_FETCH;
        S_FETCH:  if (bus.MemReady) state <= S_DECODE;
        S_DECODE: begin
          if      (cls[CL_MEM])   state <= S_MEMADR;
          else if (cls[CL_R])     state <= S_EXECR;
          else if (cls[CL_I])     state <= S_EXECI;
          else if (cls[CL_BR])    state <= S_BRANCH;
          else if (cls[CL_JAL])   state <= S_JAL;
          else if (cls[CL_JALR])  state <= S_JALR;
          else if (cls[CL_UPPER]) state <= S_UPPER;
          else                    state <= S_TRAP;
        end
        S_MEMADR: state <= bus.Opcode[5] ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.MemReady) state <= S_MEMWB;
        S_MEMWR:  if (bus.MemReady) state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL, S_LINK, S_UPPER: state <= S_ALUWB;
        S_JALR:   state <= S_LINK;
        S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
        default:  state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    bus.ALUOp     = ALU_ADD;
    bus.ALUSrcA   = SA_PC;
    bus.ALUSrcB   = SB_REGB;
    bus.ResultSrc = RS_ALUOUT;
    bus.AdrSrc    = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead   = 1'b1;
        bus.ALUSrcA   = SA_PC;
        bus.ALUSrcB   = SB_FOUR;
        bus.ResultSrc = RS_ALURES;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
      end
      // branch/JAL target is precomputed into ALUOut here
      S_DECODE: begin bus.ALUSrcA = SA_OLDPC; bus.ALUSrcB = SB_IMM; end
      S_MEMADR: begin bus.ALUSrcA = SA_REGA;  bus.ALUSrcB = SB_IMM; end
      S_MEMRD:  begin bus.AdrSrc = 1'b1; bus.MemRead = 1'b1; end
      S_MEMWB: begin
        bus.ResultSrc = RS_DATA;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc    = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.InstrDone = bus.MemReady;
      end
      S_EXECR: begin bus.ALUSrcA = SA_REGA; bus.ALUSrcB = SB_REGB; bus.ALUOp = ALU_RTYPE; end
      S_EXECI: begin bus.ALUSrcA = SA_REGA; bus.ALUSrcB = SB_IMM;  bus.ALUOp = ALU_ITYPE; end
      S_ALUWB: begin
        bus.ResultSrc = RS_ALUOUT;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = SA_REGA;
        bus.ALUSrcB   = SB_REGB;
        bus.ALUOp     = ALU_SUB;
        bus.InstrDone = 1'b1;
        bus.PCWrite   = bus.Zero ^ bus.Funct3[0];
      end
      S_JAL: begin
        bus.PCWrite = 1'b1;
        bus.ALUSrcA = SA_OLDPC;
        bus.ALUSrcB = SB_FOUR;
        bus.ALUOp   = ALU_PCADD;
      end
      S_JALR: begin
        bus.ALUSrcA   = SA_REGA;
        bus.ALUSrcB   = SB_IMM;
        bus.ALUOp     = ALU_PCADD;
        bus.ResultSrc = RS_ALURES;
        bus.PCWrite   = 1'b1;
      end
      S_LINK:  begin bus.ALUSrcA = SA_OLDPC; bus.ALUSrcB = SB_FOUR; bus.ALUOp = ALU_PCADD; end
      // LUI adds to zero, AUIPC to the old PC
      S_UPPER: begin
        bus.ALUSrcA = bus.Opcode[5] ? SA_ZERO : SA_OLDPC;
        bus.ALUSrcB = SB_IMM;
        bus.ALUOp   = ALU_PCADD;
      end
      S_TRAP:  bus.Illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-cycle output vectors checked mid-cycle.
module tb_mc_main_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  mc_main_control_if bus();
  mc_main_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // {ALUOp, A, B, ResultSrc, AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, InstrDone, Illegal}
  function automatic logic [16:0] ov(input int op, input int a, input int b, input int rs,
                                     input int adr, input int mr, input int mw, input int ir,
                                     input int pc, input int rw, input int dn, input int il);
    return {op[2:0], a[1:0], b[1:0], rs[1:0], adr[0], mr[0], mw[0], ir[0], pc[0], rw[0], dn[0], il[0]};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.InstrDone, bus.Illegal};
  endfunction

  localparam logic [16:0] X_ZERO = 17'd0;
  localparam logic [16:0] X_F1   = ov(0,0,2,2, 0,1,0,1,1,0,0,0);
  localparam logic [16:0] X_F0   = ov(0,0,2,2, 0,1,0,0,0,0,0,0);
  localparam logic [16:0] X_DEC  = ov(0,1,1,0, 0,0,0,0,0,0,0,0);
  localparam logic [16:0] X_EXR  = ov(2,2,0,0, 0,0,0,0,0,0,0,0);
  localparam logic [16:0] X_EXI  = ov(3,2,1,0, 0,0,0,0,0,0,0,0);
  localparam logic [16:0] X_AWB  = ov(0,0,0,0, 0,0,0,0,0,1,1,0);
  localparam logic [16:0] X_MADR = ov(0,2,1,0, 0,0,0,0,0,0,0,0);
  localparam logic [16:0] X_MRD  = ov(0,0,0,0, 1,1,0,0,0,0,0,0);
  localparam logic [16:0] X_MWB  = ov(0,0,0,1, 0,0,0,0,0,1,1,0);
  localparam logic [16:0] X_MWR0 = ov(0,0,0,0, 1,0,1,0,0,0,0,0);
  localparam logic [16:0] X_MWR1 = ov(0,0,0,0, 1,0,1,0,0,0,1,0);
  localparam logic [16:0] X_BRT  = ov(1,2,0,0, 0,0,0,0,1,0,1,0);
  localparam logic [16:0] X_BRN  = ov(1,2,0,0, 0,0,0,0,0,0,1,0);
  localparam logic [16:0] X_JAL  = ov(4,1,2,0, 0,0,0,0,1,0,0,0);
  localparam logic [16:0] X_JALR = ov(4,2,1,2, 0,0,0,0,1,0,0,0);
  localparam logic [16:0] X_LINK = ov(4,1,2,0, 0,0,0,0,0,0,0,0);
  localparam logic [16:0] X_LUI  = ov(4,3,1,0, 0,0,0,0,0,0,0,0);
  localparam logic [16:0] X_AUI  = ov(4,1,1,0, 0,0,0,0,0,0,0,0);
  localparam logic [16:0] X_TRAP = ov(0,0,0,0, 0,0,0,0,0,0,0,1);

  task automatic test_reset();
    bus.Opcode = 7'd0; bus.Funct3 = 3'd0; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    #1; checks++;
    if (obs() !== X_ZERO) begin fails++; $display("FAIL reset_hold got %h want %h", obs(), X_ZERO); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1; checks++;
    if (obs() !== X_ZERO) begin fails++; $display("FAIL reset_boot got %h want %h", obs(), X_ZERO); end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [16:0] e[$] = '{X_F1, X_DEC, X_EXR, X_AWB};
    bus.Opcode = 7'b0110011; bus.Funct3 = 3'd0;
    for (int i = 0; i < e.size(); i++) begin
      bus.MemReady = 1'b1; #1; checks++;
      if (obs() !== e[i]) begin fails++; $display("FAIL rtype cyc%0d got %h want %h", i, obs(), e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_itype();
    logic [16:0] e[$] = '{X_F1, X_DEC, X_EXI, X_AWB};
    bus.Opcode = 7'b0010011; bus.Funct3 = 3'd7;
    for (int i = 0; i < e.size(); i++) begin
      bus.MemReady = 1'b1; #1; checks++;
      if (obs() !== e[i]) begin fails++; $display("FAIL itype cyc%0d got %h want %h", i, obs(), e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] e[$] = '{X_F1, X_DEC, X_MADR, X_MRD, X_MRD, X_MRD, X_MRD, X_MWB};
    bit          r[$] = '{1, 1, 1, 0, 0, 0, 1, 0};
    bus.Opcode = 7'b0000011; bus.Funct3 = 3'd2;
    for (int i = 0; i < e.size(); i++) begin
      bus.MemReady = r[i]; #1; checks++;
      if (obs() !== e[i]) begin fails++; $display("FAIL load cyc%0d got %h want %h", i, obs(), e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_store_wait();
    logic [16:0] e[$] = '{X_F1, X_DEC, X_MADR, X_MWR0, X_MWR0, X_MWR1};
    bit          r[$] = '{1, 0, 0, 0, 0, 1};
    bus.Opcode = 7'b0100011; bus.Funct3 = 3'd2;
    for (int i = 0; i < e.size(); i++) begin
      bus.MemReady = r[i]; #1; checks++;
      if (obs() !== e[i]) begin fails++; $display("FAIL store cyc%0d got %h want %h", i, obs(), e[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3[3] = '{3'b000, 3'b001, 3'b001};
    bit          z[3]  = '{1, 1, 0};
    logic [16:0] eb[3] = '{X_BRT, X_BRN, X_BRT};
    for (int c = 0; c < 3; c++) begin
      logic [16:0] e[$];
      e = '{X_F1, X_DEC, eb[c]};
      bus.Opcode = 7'b1100011; bus.Funct3 = f3[c]; bus.Zero = z[c];
      for (int i = 0; i < e.size(); i++) begin
        bus.MemReady = 1'b1; #1; checks++;
        if (obs() !== e[i]) begin fails++; $display("FAIL branch%0d cyc%0d got %h want %h", c, i, obs(), e[i]); end
        @(negedge clk);
      end
    end
    bus.Zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [16:0] e[$] = '{X_F0, X_F0, X_F1, X_DEC, X_JAL, X_AWB};
    bit          r[$] = '{0, 0, 1, 0, 0, 0};
    logic [16:0] ej[$] = '{X_F1, X_DEC, X_JALR, X_LINK, X_AWB};
    bus.Opcode = 7'b1101111;
    for (int i = 0; i < e.size(); i++) begin
      bus.MemReady = r[i]; #1; checks++;
      if (obs() !== e[i]) begin fails++; $display("FAIL jal cyc%0d got %h want %h", i, obs(), e[i]); end
      @(negedge clk);
    end
    bus.Opcode = 7'b1100111; bus.Funct3 = 3'd0;
    for (int i = 0; i < ej.size(); i++) begin
      bus.MemReady = 1'b1; #1; checks++;
      if (obs() !== ej[i]) begin fails++; $display("FAIL jalr cyc%0d got %h want %h", i, obs(), ej[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_upper();
    logic [6:0]  op[2] = '{7'b0110111, 7'b0010111};
    logic [16:0] eu[2] = '{X_LUI, X_AUI};
    for (int c = 0; c < 2; c++) begin
      logic [16:0] e[$];
      e = '{X_F1, X_DEC, eu[c], X_AWB};
      bus.Opcode = op[c];
      for (int i = 0; i < e.size(); i++) begin
        bus.MemReady = 1'b1; #1; checks++;
        if (obs() !== e[i]) begin fails++; $display("FAIL upper%0d cyc%0d got %h want %h", c, i, obs(), e[i]); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_trap();
    logic [16:0] e[$] = '{X_F1, X_DEC};
    logic [16:0] eb[$] = '{X_F1, X_DEC, X_TRAP, X_TRAP};
    bus.Opcode = 7'b0000000; bus.Funct3 = 3'd0;
    for (int i = 0; i < 14; i++) begin
      bus.MemReady = (i < 2) ? 1'b1 : i[0];
      bus.Zero = i[1];
      #1; checks++;
      if (obs() !== ((i < 2) ? e[i] : X_TRAP)) begin
        fails++; $display("FAIL trap cyc%0d got %h want %h", i, obs(), (i < 2) ? e[i] : X_TRAP);
      end
      @(negedge clk);
    end
    bus.Zero = 1'b0;
    rst_n = 1'b0; #1; checks++;
    if (obs() !== X_ZERO) begin fails++; $display("FAIL trap_clear got %h want %h", obs(), X_ZERO); end
    @(negedge clk);
    rst_n = 1'b1; #1; checks++;
    if (obs() !== X_ZERO) begin fails++; $display("FAIL trap_boot got %h want %h", obs(), X_ZERO); end
    @(negedge clk);
    bus.Opcode = 7'b1100011; bus.Funct3 = 3'b100;
    for (int i = 0; i < eb.size(); i++) begin
      bus.MemReady = 1'b1; #1; checks++;
      if (obs() !== eb[i]) begin fails++; $display("FAIL brtrap cyc%0d got %h want %h", i, obs(), eb[i]); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midwrite();
    logic [16:0] e[$] = '{X_F1, X_DEC, X_MADR, X_MWR0};
    bit          r[$] = '{1, 1, 1, 0};
    bus.Opcode = 7'b0100011; bus.Funct3 = 3'd2;
    for (int i = 0; i < e.size(); i++) begin
      bus.MemReady = r[i]; #1; checks++;
      if (obs() !== e[i]) begin fails++; $display("FAIL midwr cyc%0d got %h want %h", i, obs(), e[i]); end
      if (i < e.size() - 1) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1; checks++;
    if (obs() !== X_ZERO) begin fails++; $display("FAIL midwr_async got %h want %h", obs(), X_ZERO); end
    @(negedge clk);
    rst_n = 1'b1; #1; checks++;
    if (obs() !== X_ZERO) begin fails++; $display("FAIL midwr_boot got %h want %h", obs(), X_ZERO); end
    @(negedge clk);
    bus.MemReady = 1'b0; #1; checks++;
    if (obs() !== X_F0) begin fails++; $display("FAIL midwr_fetch got %h want %h", obs(), X_F0); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_store_wait();
    test_branch();
    test_jump();
    test_upper();
    test_trap();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multicycle main-control FSM for the RISC-V core. It sequences the shared datapath through fetch, decode, execute, memory and writeback. It drives the 3-bit ALUOp consumed by the ALU control decoder, plus datapath mux selects and write strobes. Memory accesses wait on a ready handshake, so memory latency is variable.

## Interface
- No parameters.
- clk  in  1  rising-edge system clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  7  instruction register bits [6:0]; stable after the fetch IRWrite
- Funct3  in  3  instruction register bits [14:12]
- Zero  in  1  ALU result-equals-zero flag
- MemReady  in  1  memory has completed the current read or write this cycle
- ALUOp  out  3  0 = add (address), 1 = sub (branch), 2 = R-type, 3 = I-type, 4 = add (PC/upper)
- ALUSrcA  out  2  0 = PC, 1 = OldPC, 2 = RegA, 3 = zero
- ALUSrcB  out  2  0 = RegB, 1 = ImmExt, 2 = constant 4
- ResultSrc  out  2  0 = ALUOut, 1 = Data, 2 = ALU result
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead, MemWrite, IRWrite, PCWrite, RegWrite  out  1 each  strobes
- InstrDone  out  1  one-cycle pulse in the final cycle of each instruction
- Illegal  out  1  sticky flag for an unsupported opcode or branch funct3

## Operation
- States: BOOT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, UPPER, TRAP.
- Outputs not listed for a state are 0. All outputs are Moore-decoded from the state, except strobes marked "if".
- BOOT: all outputs 0. Next state is FETCH.
- FETCH: AdrSrc=0, MemRead=1, A=0, B=2, ALUOp=0, ResultSrc=2.
  - IRWrite and PCWrite are set only if MemReady.
  - If MemReady, go to DECODE; otherwise stay in FETCH.
- DECODE: A=1, B=1, ALUOp=0 (branch/JAL target into ALUOut). Dispatch on Opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH if Funct3 is 000 or 001; otherwise TRAP
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UPPER
  - any other opcode → TRAP
- MEMADR: A=2, B=1, ALUOp=0. Next state is MEMRD if Opcode[5]=0, MEMWR if Opcode[5]=1.
- MEMRD: AdrSrc=1, MemRead=1. Wait for MemReady, then go to MEMWB.
- MEMWB: ResultSrc=1, RegWrite=1, InstrDone=1. Next state is FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. InstrDone is set if MemReady. Wait for MemReady, then go to FETCH.
- EXECR: A=2, B=0, ALUOp=2. Next state is ALUWB.
- EXECI: A=2, B=1, ALUOp=3. Next state is ALUWB.
- ALUWB: ResultSrc=0, RegWrite=1, InstrDone=1. Next state is FETCH.
- BRANCH: A=2, B=0, ALUOp=1, ResultSrc=0, InstrDone=1. PCWrite is set if (Zero ^ Funct3[0]). Next state is FETCH.
- JAL: ResultSrc=0, PCWrite=1, A=1, B=2, ALUOp=4. Next state is ALUWB.
- JALR: A=2, B=1, ALUOp=4, ResultSrc=2, PCWrite=1. Next state is LINK.
- LINK: A=1, B=2, ALUOp=4. Next state is ALUWB.
- UPPER: A = (Opcode[5] ? 3 : 1), B=1, ALUOp=4. Next state is ALUWB.
- TRAP: Illegal=1, all strobes 0. Stays in TRAP until reset.

## Timing
- Reset: asserting rst_n=0 forces BOOT immediately, asynchronously. All outputs go to 0 (including Illegal) with no clock edge. This holds even mid-instruction or while a memory handshake is pending.
- The first FETCH is the first cycle after rst_n deasserts.
- Latency with MemReady tied high:
  - R-type, I-type, JAL, LUI, AUIPC: 4 cycles
  - JALR: 5 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
- Each wait cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle. All outputs hold steady while waiting.
- MemReady is ignored in every other state.
- InstrDone asserts exactly once per instruction and never in TRAP.

## Structure
- Package mc_pkg holds:
  - state enum
  - opcode localparams
  - ALUOp codes 0–4
  - ALUSrcA, ALUSrcB and ResultSrc encodings (shared with the datapath muxes and ALU control)
- One sub-module, mc_opcode_decode: combinational Opcode/Funct3 classifier producing a one-hot instruction class, used for DECODE dispatch and TRAP detection.

## Test plan
- R-type add (Opcode 0110011), MemReady=1 → states FETCH, DECODE, EXECR, ALUWB.
  - ALUOp=2 in EXECR.
  - RegWrite=1 and InstrDone=1 in cycle 4 only.
- Load with MemReady low for 3 cycles in MEMRD → MemRead=1 and AdrSrc=1 held for 4 cycles, then MEMWB with ResultSrc=1.
  - Total is 8 cycles.
- beq with Zero=1 → PCWrite=1 in BRANCH.
- bne with Zero=1 → PCWrite=0 in BRANCH.
- Both branch cases: ALUOp=1 and total of 3 cycles.
- Opcode 0000000, or branch with Funct3=100 → TRAP.
  - Illegal=1 persists for 10+ cycles with no strobes.
  - rst_n pulse clears it, then BOOT, then FETCH.
- rst_n asserted during MEMWR with MemReady=0 → MemWrite drops to 0 with no clock edge.
  - After release: one BOOT cycle, then FETCH with MemRead=1.
